wishbone_line_master: RTL and testbench
=======================================

# wishbone_line_master

Wishbone classic-cycle bus master between the CPU-side line adapter and the Wishbone memory slave. Accepts one 128-bit line request at a time (12-bit line address, 16-bit byte select, 128-bit pre-shifted write data) and runs the bus cycle. Handles slave retries up to a limit. Keeps a one-line read buffer so that repeated reads of the same line complete without a bus cycle. Writes are write-through.

## Interface
- RETRY_LIMIT, 4: maximum `wb_rty` responses per request; the request fails with error when this count is reached.
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- mem_read  in  1  read request; held until `mem_resp`.
- mem_write  in  1  write request; held until `mem_resp`; wins if both are high.
- mem_address  in  12  line address (lc3b_address).
- write_data_mem  in  128  byte-lane-aligned write line (lc3b_c_line).
- select  in  16  byte enables; bit i covers data bits [8i+7:8i].
- mem_rdata_line  out  128  registered read line.
- mem_resp  out  1  one-cycle completion pulse.
- mem_error  out  1  high with `mem_resp` when the retry limit was hit.
- wb_adr  out  12  bus line address.
- wb_dat_o  out  128  bus write data.
- wb_sel  out  16  bus byte select.
- wb_cyc  out  1  bus cycle.
- wb_stb  out  1  bus strobe.
- wb_we  out  1  bus write enable.
- wb_dat_i  in  128  bus read data.
- wb_ack  in  1  slave acknowledge.
- wb_rty  in  1  slave retry.

## Operation
- States: IDLE, BUS, BACKOFF, RESP.
- IDLE:
  - `mem_write` high: latch address/data/select into request regs, clear retry count, go to BUS.
  - Else `mem_read` high, with buffer valid and tag == `mem_address`: copy buffer data to `mem_rdata_line`, clear the error flag, go to RESP. This is a hit; no bus activity.
  - Else `mem_read` high: latch request, go to BUS.
- BUS: `wb_cyc` = `wb_stb` = 1. `wb_adr`, `wb_dat_o`, `wb_sel`, `wb_we` are driven from the request regs and held stable until the cycle ends.
  - For reads, `wb_sel` = 16'hFFFF; the full line is always fetched.
  - `wb_ack` (has priority if `wb_rty` is high in the same cycle):
    - Read: load `wb_dat_i` into `mem_rdata_line` and the buffer, set the buffer tag and valid bit.
    - Write with buffer tag hit: merge each byte i where `select[i]` is set into the buffer; `mem_rdata_line` is unchanged.
    - Write with buffer miss: buffer is untouched.
    - In all ack cases the error flag is 0 and the next state is RESP.
  - `wb_rty`: increment retry count. If the new count == RETRY_LIMIT, set the error flag and go to RESP with no buffer or rdata update. Otherwise go to BACKOFF.
- BACKOFF: `wb_cyc` = `wb_stb` = 0 for exactly one cycle, then back to BUS with the same request.
- RESP: `mem_resp` = 1 and `mem_error` = error flag, for one cycle; then go to IDLE.
  - The CPU must drop or change its request on the edge at which it sees `mem_resp`. A request still high in IDLE is treated as new.
- Retry count width: clog2(RETRY_LIMIT+1) bits. It never wraps because it is cleared at each new request.
- Reset (asynchronous, any state including mid-bus-cycle):
  - state → IDLE;
  - `wb_cyc`, `wb_stb`, `wb_we`, `mem_resp`, `mem_error` → 0;
  - `wb_adr`, `wb_dat_o`, `wb_sel`, `mem_rdata_line` → 0;
  - buffer valid → 0;
  - retry count → 0.

## Timing
- All outputs are registered or decoded from state only; there are no combinational paths from input to output.
- Read hit: request sampled at edge 0; `mem_resp` high in cycle 1. Latency 1 cycle.
- Miss or write: request sampled at edge 0; `wb_cyc`/`wb_stb` high from cycle 1. Ack sampled at edge n; `mem_resp` high in cycle n+1.
- Each retry adds 2 cycles: the rty edge plus one BACKOFF cycle.
- Throughput: at most one request per 2 cycles (hit) or 3 cycles (zero-wait bus).
- `wb_ack`/`wb_rty` outside BUS are ignored.

## Test plan
- Read miss then hit: read 12'h0A3, slave acks in cycle 2 with data 128'h0123…CDEF → `mem_resp` in cycle 3 with that data. The same read again gives `mem_resp` 1 cycle later, with `wb_cyc` never asserted.
- Write-through merge:
  - after buffering 12'h0A3 with 128'h0, write `select` = 16'h0030 and data bytes 5:4 = 16'hBEEF;
  - check `wb_sel` = 16'h0030 and `wb_we` = 1 on the bus;
  - a following read of 12'h0A3 is a hit returning 16'hBEEF at bits [47:32] and zero elsewhere.
- Write miss leaves the buffer alone: buffer holds 12'h0A3; write to 12'h0A4; a read of 12'h0A3 is still a hit.
- Retry then success: slave gives `wb_rty` twice, then `wb_ack` → two one-cycle `wb_cyc` drops; `mem_resp` = 1, `mem_error` = 0; total latency 1+2+2+1 cycles after the first strobe.
- Retry exhaustion: `wb_rty` on every strobe with RETRY_LIMIT = 4 → 4 strobes, then `mem_resp` = `mem_error` = 1; buffer and `mem_rdata_line` unchanged. Simultaneous `wb_ack` and `wb_rty` completes normally.
- Reset mid-cycle: assert `rst` while `wb_stb` = 1 → `wb_cyc`/`wb_stb` drop immediately without waiting for a clock edge; the next read of the previously buffered line is a miss.

Source files
------------

// File: rtl/wishbone_line_master.sv
// Wishbone classic-cycle master for 128-bit cache lines, with slave-retry handling
// and a one-line write-through read buffer that serves repeated reads without a bus cycle.
module wishbone_line_master #(
    parameter int unsigned RETRY_LIMIT = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           mem_read,
    input  logic           mem_write,
    input  logic [11:0]    mem_address,
    input  logic [127:0]   write_data_mem,
    input  logic [15:0]    select,
    output logic [127:0]   mem_rdata_line,
    output logic           mem_resp,
    output logic           mem_error,
    output logic [11:0]    wb_adr,
    output logic [127:0]   wb_dat_o,
    output logic [15:0]    wb_sel,
    output logic           wb_cyc,
    output logic           wb_stb,
    output logic           wb_we,
    input  logic [127:0]   wb_dat_i,
    input  logic           wb_ack,
    input  logic           wb_rty
);

    localparam int unsigned CNT_W = $clog2(RETRY_LIMIT + 1);
    localparam logic [CNT_W-1:0] RTY_MAX = CNT_W'(RETRY_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUS     = 2'd1,
        S_BACKOFF = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [11:0]      r_adr;
    logic [127:0]     r_dat;
    logic [15:0]      r_sel;
    logic             r_we;
    logic [CNT_W-1:0] r_rty_cnt;
    logic             r_err;
    logic [127:0]     r_rdata;

    logic             r_buf_valid;
    logic [11:0]      r_buf_tag;
    logic [127:0]     r_buf_data;

    logic             w_hit;
    logic             w_read_hit;
    logic             w_start;
    logic             w_bus_ack;
    logic             w_bus_rty;
    logic [CNT_W-1:0] w_rty_inc;
    logic             w_rty_last;
    logic             w_wr_buf_hit;

    // Replace each selected byte lane of the old line with the new data.
    function automatic logic [127:0] merge_bytes(input logic [127:0] old_line,
                                                 input logic [127:0] new_line,
                                                 input logic [15:0]  byte_sel);
        logic [127:0] res;
        res = old_line;
        for (int i = 0; i < 16; i++) begin
            if (byte_sel[i]) begin
                res[8*i +: 8] = new_line[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_line[8*i +: 8];
            end
        end
        return res;
    endfunction

    assign w_hit        = r_buf_valid && (r_buf_tag == mem_address);
    assign w_read_hit   = (r_state == S_IDLE) && !mem_write && mem_read && w_hit;
    assign w_start      = (r_state == S_IDLE) && (mem_write || (mem_read && !w_hit));
    assign w_bus_ack    = (r_state == S_BUS) && wb_ack;
    assign w_bus_rty    = (r_state == S_BUS) && wb_rty && !wb_ack;
    assign w_rty_inc    = r_rty_cnt + CNT_W'(1);
    assign w_rty_last   = (w_rty_inc == RTY_MAX);
    assign w_wr_buf_hit = r_buf_valid && (r_buf_tag == r_adr);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; ack wins over a simultaneous retry.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (mem_write) begin
                    w_state_next = S_BUS;
                end else if (mem_read && w_hit) begin
                    w_state_next = S_RESP;
                end else if (mem_read) begin
                    w_state_next = S_BUS;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_BUS: begin
                if (wb_ack) begin
                    w_state_next = S_RESP;
                end else if (wb_rty) begin
                    if (w_rty_last) begin
                        w_state_next = S_RESP;
                    end else begin
                        w_state_next = S_BACKOFF;
                    end
                end else begin
                    w_state_next = S_BUS;
                end
            end
            S_BACKOFF: w_state_next = S_BUS;
            S_RESP:    w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    // Request capture; reads always fetch the whole line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_adr <= 12'd0;
            r_dat <= 128'd0;
            r_sel <= 16'd0;
            r_we  <= 1'b0;
        end else if (w_start) begin
            r_adr <= mem_address;
            r_dat <= write_data_mem;
            r_sel <= mem_write ? select : 16'hFFFF;
            r_we  <= mem_write;
        end else begin
            r_adr <= r_adr;
            r_dat <= r_dat;
            r_sel <= r_sel;
            r_we  <= r_we;
        end
    end

    // Retry counter, cleared per request so it never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rty_cnt <= {CNT_W{1'b0}};
        end else if (w_start) begin
            r_rty_cnt <= {CNT_W{1'b0}};
        end else if (w_bus_rty) begin
            r_rty_cnt <= w_rty_inc;
        end else begin
            r_rty_cnt <= r_rty_cnt;
        end
    end

    // Error flag reported alongside the response pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_read_hit || w_start || w_bus_ack) begin
            r_err <= 1'b0;
        end else if (w_bus_rty && w_rty_last) begin
            r_err <= 1'b1;
        end else begin
            r_err <= r_err;
        end
    end

    // Read data returned to the CPU: from the buffer on a hit, from the bus on a read ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= 128'd0;
        end else if (w_read_hit) begin
            r_rdata <= r_buf_data;
        end else if (w_bus_ack && !r_we) begin
            r_rdata <= wb_dat_i;
        end else begin
            r_rdata <= r_rdata;
        end
    end

    // Line buffer: filled on read acks, kept coherent by merging acknowledged writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf_valid <= 1'b0;
            r_buf_tag   <= 12'd0;
            r_buf_data  <= 128'd0;
        end else if (w_bus_ack && !r_we) begin
            r_buf_valid <= 1'b1;
            r_buf_tag   <= r_adr;
            r_buf_data  <= wb_dat_i;
        end else if (w_bus_ack && w_wr_buf_hit) begin
            r_buf_valid <= r_buf_valid;
            r_buf_tag   <= r_buf_tag;
            r_buf_data  <= merge_bytes(r_buf_data, r_dat, r_sel);
        end else begin
            r_buf_valid <= r_buf_valid;
            r_buf_tag   <= r_buf_tag;
            r_buf_data  <= r_buf_data;
        end
    end

    assign wb_cyc         = (r_state == S_BUS);
    assign wb_stb         = (r_state == S_BUS);
    assign wb_we          = r_we;
    assign wb_adr         = r_adr;
    assign wb_dat_o       = r_dat;
    assign wb_sel         = r_sel;
    assign mem_resp       = (r_state == S_RESP);
    assign mem_error      = (r_state == S_RESP) && r_err;
    assign mem_rdata_line = r_rdata;

endmodule

// File: tb/tb_wishbone_line_master.sv
// Randomized self-checking bench for wishbone_line_master: a behavioural slave plus a
// line-buffer reference model predicting response data, error, latency and strobe count.
module tb_wishbone_line_master;

    logic         clk;
    logic         rst;
    logic         mem_read;
    logic         mem_write;
    logic [11:0]  mem_address;
    logic [127:0] write_data_mem;
    logic [15:0]  select;
    logic [127:0] mem_rdata_line;
    logic         mem_resp;
    logic         mem_error;
    logic [11:0]  wb_adr;
    logic [127:0] wb_dat_o;
    logic [15:0]  wb_sel;
    logic         wb_cyc;
    logic         wb_stb;
    logic         wb_we;
    logic [127:0] wb_dat_i;
    logic         wb_ack;
    logic         wb_rty;

    int n_checks;
    int n_pass;

    // Reference model of the line buffer and the last returned line.
    bit           m_valid;
    logic [11:0]  m_tag;
    logic [127:0] m_buf;
    logic [127:0] m_rdata;

    wishbone_line_master #(.RETRY_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .write_data_mem(write_data_mem), .select(select),
        .mem_rdata_line(mem_rdata_line), .mem_resp(mem_resp), .mem_error(mem_error),
        .wb_adr(wb_adr), .wb_dat_o(wb_dat_o), .wb_sel(wb_sel),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we),
        .wb_dat_i(wb_dat_i), .wb_ack(wb_ack), .wb_rty(wb_rty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One CPU request with a scripted slave: n_rty retries, then ack (plus rty if both).
    task automatic do_request(input bit we, input logic [11:0] addr, input logic [127:0] wdata,
                              input logic [15:0] sel, input logic [127:0] sdata, input int n_rty,
                              input int wmin, input int wmax, input bit both, input string name);
        bit exp_hit, exp_err, done, prev;
        int exp_att, att, strobes, cur_wait, waited, wait_sum, lat, exp_lat;
        logic [15:0] exp_sel;
        exp_hit  = !we && m_valid && (m_tag == addr);
        exp_err  = !exp_hit && (n_rty >= 4);
        exp_att  = exp_hit ? 0 : ((n_rty >= 4) ? 4 : n_rty + 1);
        exp_sel  = we ? sel : 16'hFFFF;
        done = 1'b0; prev = 1'b0; att = 0; strobes = 0; cur_wait = 0; waited = 0;
        wait_sum = 0; lat = 0;
        if (exp_hit) begin
            m_rdata = m_buf;
        end else if (!exp_err && !we) begin
            m_rdata = sdata; m_buf = sdata; m_tag = addr; m_valid = 1'b1;
        end else if (!exp_err && m_valid && (m_tag == addr)) begin
            for (int i = 0; i < 16; i++)
                if (sel[i]) m_buf[8*i +: 8] = wdata[8*i +: 8];
        end
        @(negedge clk);
        mem_write = we; mem_read = !we; mem_address = addr;
        write_data_mem = wdata; select = sel; wb_dat_i = sdata;
        for (int cyc = 1; cyc <= 300 && !done; cyc++) begin
            @(negedge clk);
            wb_ack = 1'b0; wb_rty = 1'b0;
            if (mem_resp) begin
                done = 1'b1; lat = cyc;
                mem_read = 1'b0; mem_write = 1'b0;
            end else if (wb_cyc && wb_stb) begin
                if (!prev) begin
                    strobes++; cur_wait = $urandom_range(wmax, wmin); waited = 0;
                end
                n_checks++;
                if ((wb_adr !== addr) || (wb_we !== we) || (wb_sel !== exp_sel))
                    $display("FAIL %s bus_ctrl: adr=%h we=%b sel=%h, required adr=%h we=%b sel=%h",
                             name, wb_adr, wb_we, wb_sel, addr, we, exp_sel);
                else n_pass++;
                if (we) begin
                    n_checks++;
                    if (wb_dat_o !== wdata)
                        $display("FAIL %s bus_data: got %h, required %h", name, wb_dat_o, wdata);
                    else n_pass++;
                end
                if (waited == cur_wait) begin
                    wait_sum += cur_wait;
                    if (att < n_rty) wb_rty = 1'b1;
                    else begin wb_ack = 1'b1; wb_rty = both; end
                    att++;
                end else begin
                    waited++;
                end
            end
            prev = wb_cyc && wb_stb && !mem_resp;
        end
        n_checks++;
        if (!done) begin
            $display("FAIL %s timeout: no mem_resp within 300 cycles, required one", name);
            mem_read = 1'b0; mem_write = 1'b0; wb_ack = 1'b0; wb_rty = 1'b0;
            return;
        end
        n_pass++;
        exp_lat = exp_hit ? 1 : (wait_sum + exp_att + (exp_att - 1) + 1);
        n_checks++;
        if (mem_error !== exp_err)
            $display("FAIL %s error: got %b, required %b", name, mem_error, exp_err);
        else n_pass++;
        n_checks++;
        if (mem_rdata_line !== m_rdata)
            $display("FAIL %s rdata: got %h, required %h", name, mem_rdata_line, m_rdata);
        else n_pass++;
        n_checks++;
        if (strobes !== exp_att)
            $display("FAIL %s strobes: got %0d, required %0d", name, strobes, exp_att);
        else n_pass++;
        n_checks++;
        if (lat !== exp_lat)
            $display("FAIL %s latency: got %0d, required %0d", name, lat, exp_lat);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ((mem_resp !== 1'b0) || (wb_cyc !== 1'b0))
            $display("FAIL %s pulse: resp=%b cyc=%b after response, required 0 0",
                     name, mem_resp, wb_cyc);
        else n_pass++;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_valid = 1'b0; m_rdata = 128'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({wb_cyc, wb_stb, wb_we, mem_resp, mem_error} !== 5'b00000)
            $display("FAIL reset_ctrl: cyc/stb/we/resp/err=%b, required 00000",
                     {wb_cyc, wb_stb, wb_we, mem_resp, mem_error});
        else n_pass++;
        n_checks++;
        if ((wb_adr !== 12'd0) || (wb_dat_o !== 128'd0) || (wb_sel !== 16'd0) ||
            (mem_rdata_line !== 128'd0))
            $display("FAIL reset_data: adr=%h sel=%h dat=%h rdata=%h, required all zero",
                     wb_adr, wb_sel, wb_dat_o, mem_rdata_line);
        else n_pass++;
        rst = 1'b0;
        m_valid = 1'b0; m_rdata = 128'd0;
    endtask

    task automatic test_read_miss_hit();
        logic [127:0] line;
        line = 128'h0123456789ABCDEF0123456789ABCDEF;
        do_request(1'b0, 12'h0A3, 128'd0, 16'h0000, line, 0, 1, 1, 1'b0, "read_miss");
        do_request(1'b0, 12'h0A3, 128'd0, 16'h0000, rand128(), 0, 0, 0, 1'b0, "read_hit");
    endtask

    task automatic test_write_merge();
        logic [127:0] wd;
        logic [127:0] exp_line;
        pulse_reset();
        do_request(1'b0, 12'h0A3, 128'd0, 16'h0000, 128'd0, 0, 0, 1, 1'b0, "fill_zero");
        wd = rand128();
        wd[47:32] = 16'hBEEF;
        do_request(1'b1, 12'h0A3, wd, 16'h0030, rand128(), 0, 0, 1, 1'b0, "write_merge");
        do_request(1'b0, 12'h0A3, 128'd0, 16'h0000, rand128(), 0, 0, 0, 1'b0, "merge_hit");
        exp_line = 128'd0;
        exp_line[47:32] = 16'hBEEF;
        n_checks++;
        if (mem_rdata_line !== exp_line)
            $display("FAIL merge_line: got %h, required %h", mem_rdata_line, exp_line);
        else n_pass++;
    endtask

    task automatic test_write_miss();
        do_request(1'b1, 12'h0A4, rand128(), 16'hFFFF, rand128(), 0, 0, 1, 1'b0, "write_miss");
        do_request(1'b0, 12'h0A3, 128'd0, 16'h0000, rand128(), 0, 0, 0, 1'b0, "still_hit");
    endtask

    task automatic test_retry();
        do_request(1'b0, 12'h1C0, 128'd0, 16'h0000, rand128(), 2, 0, 0, 1'b0, "retry_ok");
        do_request(1'b0, 12'h1C1, 128'd0, 16'h0000, rand128(), 4, 0, 1, 1'b0, "retry_exhaust");
        do_request(1'b1, 12'h1C0, rand128(), 16'h00FF, rand128(), 5, 0, 0, 1'b0, "wr_exhaust");
        do_request(1'b0, 12'h1C2, 128'd0, 16'h0000, rand128(), 3, 0, 0, 1'b1, "ack_and_rty");
    endtask

    task automatic test_reset_mid_cycle();
        bit seen;
        do_request(1'b0, 12'h2B0, 128'd0, 16'h0000, rand128(), 0, 0, 0, 1'b0, "pre_reset_fill");
        @(negedge clk);
        mem_read = 1'b1; mem_address = 12'h2B1; wb_dat_i = rand128();
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = wb_stb;
        end
        n_checks++;
        if (!seen) $display("FAIL mid_reset_strobe: no strobe seen, required one");
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({wb_cyc, wb_stb, mem_resp} !== 3'b000)
            $display("FAIL mid_reset_async: cyc/stb/resp=%b, required 000",
                     {wb_cyc, wb_stb, mem_resp});
        else n_pass++;
        mem_read = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        m_valid = 1'b0; m_rdata = 128'd0;
        do_request(1'b0, 12'h2B0, 128'd0, 16'h0000, rand128(), 0, 0, 1, 1'b0, "post_reset_miss");
    endtask

    task automatic test_random();
        logic [11:0] addr;
        bit we;
        int n_rty;
        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 3))
                0: addr = 12'h0A3;
                1: addr = 12'h0A4;
                2: addr = 12'($urandom);
                default: addr = m_tag;
            endcase
            we    = ($urandom_range(0, 2) == 0);
            n_rty = ($urandom_range(0, 9) < 7) ? 0 : int'($urandom_range(1, 5));
            do_request(we, addr, rand128(), 16'($urandom), rand128(), n_rty, 0, 2,
                       1'($urandom_range(0, 1)), "random");
        end
    endtask

    initial begin
        n_checks = 0; n_pass = 0;
        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; mem_address = 12'd0;
        write_data_mem = 128'd0; select = 16'd0; wb_dat_i = 128'd0;
        wb_ack = 1'b0; wb_rty = 1'b0;
        m_valid = 1'b0; m_tag = 12'd0; m_buf = 128'd0; m_rdata = 128'd0;
        test_reset();
        test_read_miss_hit();
        test_write_merge();
        test_write_miss();
        test_retry();
        test_reset_mid_cycle();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
